// File: rtl/vdp_vram_slot_arbiter_if.sv
// Host request channel of the VDP VRAM slot arbiter.
// The host side uses the master modport, the arbiter the slave modport.
// Optional build macro: VDP_VRAM_HOST_READ_EN adds the host read request and response signals.
interface vdp_vram_slot_arbiter_if #(
  parameter int ADDR_W = 14
) ();
  logic              host_write_valid;
  logic              host_write_ready;
  logic [ADDR_W-1:0] host_write_address;
  logic [15:0]       host_write_data;
  logic [1:0]        host_write_en_mask;
`ifdef VDP_VRAM_HOST_READ_EN
  logic              host_read_valid;
  logic              host_read_ready;
  logic [ADDR_W-1:0] host_read_address;
  logic [31:0]       host_read_data;
  logic              host_read_data_valid;

  modport master (
    output host_write_valid, host_write_address, host_write_data, host_write_en_mask,
    input  host_write_ready,
    output host_read_valid, host_read_address,
    input  host_read_ready, host_read_data, host_read_data_valid
  );

  modport slave (
    input  host_write_valid, host_write_address, host_write_data, host_write_en_mask,
    output host_write_ready,
    input  host_read_valid, host_read_address,
    output host_read_ready, host_read_data, host_read_data_valid
  );
`else
  modport master (
    output host_write_valid, host_write_address, host_write_data, host_write_en_mask,
    input  host_write_ready
  );

  modport slave (
    input  host_write_valid, host_write_address, host_write_data, host_write_en_mask,
    output host_write_ready
  );
`endif
endinterface

// File: rtl/vdp_vram_slot_arbiter.sv
// VDP VRAM slot arbiter: a slot wheel driven by the raster position shares
// the VRAM address bus between queued host accesses, the sprite fetch and
// reserved layer-fetch slots. Host requests are buffered in a small FIFO.
// Optional build macro: VDP_VRAM_HOST_READ_EN adds host reads that share
// the FIFO with writes (writes win when both request in the same cycle).
module vdp_vram_slot_arbiter #(
  parameter int SLOT_BITS       = 3,
  parameter int HOST_SLOT       = 0,
  parameter int SPRITE_SLOT     = 1,
  parameter int READ_LATENCY    = 3,
  parameter int FIFO_DEPTH_BITS = 2,
  parameter int ADDR_W          = 14
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [10:0]              raster_x_offset,
  vdp_vram_slot_arbiter_if.slave   host,
  input  logic [ADDR_W-1:0]        vram_sprite_address,
  input  logic [15:0]              vram_read_data_even,
  input  logic [15:0]              vram_read_data_odd,
  output logic [ADDR_W-1:0]        vram_address,
  output logic [15:0]              vram_write_data_even,
  output logic [15:0]              vram_write_data_odd,
  output logic                     vram_we_even,
  output logic                     vram_we_odd,
  output logic                     vram_written,
  output logic                     vram_sprite_read_data_valid,
  output logic [FIFO_DEPTH_BITS:0] fifo_level
);
  localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
  localparam logic [SLOT_BITS-1:0]       HOST_S         = SLOT_BITS'(HOST_SLOT);
  localparam logic [SLOT_BITS-1:0]       SPRITE_S       = SLOT_BITS'(SPRITE_SLOT);
  // Truncation to SLOT_BITS gives the wrap-around of the wheel.
  localparam logic [SLOT_BITS-1:0]       SPRITE_VALID_S = SLOT_BITS'(SPRITE_SLOT + 1 + READ_LATENCY);
  localparam logic [FIFO_DEPTH_BITS:0]   FULL_LEVEL     = (FIFO_DEPTH_BITS + 1)'(DEPTH);
  localparam logic [FIFO_DEPTH_BITS:0]   LEVEL_ZERO     = (FIFO_DEPTH_BITS + 1)'(0);
  localparam logic [FIFO_DEPTH_BITS:0]   LEVEL_ONE      = (FIFO_DEPTH_BITS + 1)'(1);
  localparam logic [FIFO_DEPTH_BITS-1:0] PTR_ZERO       = FIFO_DEPTH_BITS'(0);
  localparam logic [FIFO_DEPTH_BITS-1:0] PTR_ONE        = FIFO_DEPTH_BITS'(1);
  localparam logic [ADDR_W-1:0]          ADDR_ZERO      = ADDR_W'(0);

  logic [ADDR_W-1:0]          mem_addr_r [DEPTH];
  logic [15:0]                mem_data_r [DEPTH];
  logic [1:0]                 mem_mask_r [DEPTH];
  logic [FIFO_DEPTH_BITS-1:0] wr_ptr_r;
  logic [FIFO_DEPTH_BITS-1:0] rd_ptr_r;
  logic [FIFO_DEPTH_BITS:0]   level_r;

  logic [SLOT_BITS-1:0] slot_s;
  logic                 request_valid_s;
  logic                 ready_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 head_rd_s;
  logic                 written_s;
  logic [ADDR_W-1:0]    push_addr_s;
  logic [15:0]          push_data_s;
  logic [1:0]           push_mask_s;
  logic [ADDR_W-1:0]    next_addr_s;
  logic [15:0]          next_data_s;
  logic [1:0]           next_mask_s;
  logic                 unused_s;

`ifdef VDP_VRAM_HOST_READ_EN
  logic                  mem_rd_r [DEPTH];
  logic                  push_rd_s;
  logic [READ_LATENCY:0] rd_pipe_r;
`endif

  // Select the request entering the queue; a write beats a read in the same cycle.
  always_comb begin
    push_addr_s = host.host_write_address;
    push_data_s = host.host_write_data;
    push_mask_s = host.host_write_en_mask;
`ifdef VDP_VRAM_HOST_READ_EN
    request_valid_s = host.host_write_valid | host.host_read_valid;
    if (host.host_write_valid) begin
      push_rd_s = 1'b0;
    end else begin
      push_addr_s = host.host_read_address;
      push_mask_s = 2'b00;
      push_rd_s   = 1'b1;
    end
    head_rd_s = mem_rd_r[rd_ptr_r];
`else
    request_valid_s = host.host_write_valid;
    head_rd_s       = 1'b0;
`endif
  end

  // Slot decode, queue handshake and next-cycle VRAM bus values.
  always_comb begin
    slot_s      = raster_x_offset[SLOT_BITS-1:0];
    // Ready looks only at the full flag, so a pop in the same cycle does not help.
    ready_s     = (level_r != FULL_LEVEL);
    push_s      = request_valid_s & ready_s;
    // The level is registered, so an entry becomes poppable only after its push edge.
    pop_s       = (slot_s == HOST_S) & (level_r != LEVEL_ZERO);
    next_addr_s = ADDR_ZERO;
    next_data_s = 16'h0000;
    next_mask_s = 2'b00;
    if (slot_s == HOST_S) begin
      if (pop_s) begin
        next_addr_s = mem_addr_r[rd_ptr_r];
        next_data_s = mem_data_r[rd_ptr_r];
        next_mask_s = mem_mask_r[rd_ptr_r];
      end else begin
        next_addr_s = ADDR_ZERO;
      end
    end else if (slot_s == SPRITE_S) begin
      next_addr_s = vram_sprite_address;
    end else begin
      // Reserved layer-fetch slots keep the bus idle.
      next_addr_s = ADDR_ZERO;
    end
    written_s = pop_s & ~head_rd_s & ~reset;
  end

  assign host.host_write_ready       = ready_s;
  assign vram_written                = written_s;
  assign vram_sprite_read_data_valid = (slot_s == SPRITE_VALID_S);
  assign fifo_level                  = level_r;

  // Queue pointers and occupancy; reset discards every pending entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      level_r  <= LEVEL_ZERO;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LEVEL_ONE;
        2'b01:   level_r <= level_r - LEVEL_ONE;
        default: level_r <= level_r;
      endcase
    end
  end

  // Queue storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_addr_r[wr_ptr_r] <= push_addr_s;
      mem_data_r[wr_ptr_r] <= push_data_s;
      mem_mask_r[wr_ptr_r] <= push_mask_s;
`ifdef VDP_VRAM_HOST_READ_EN
      mem_rd_r[wr_ptr_r]   <= push_rd_s;
`endif
    end
  end

  // Register the VRAM address, write data and write enables.
  always_ff @(posedge clk) begin
    if (reset) begin
      vram_address         <= ADDR_ZERO;
      vram_write_data_even <= 16'h0000;
      vram_write_data_odd  <= 16'h0000;
      vram_we_even         <= 1'b0;
      vram_we_odd          <= 1'b0;
    end else begin
      vram_address         <= next_addr_s;
      vram_write_data_even <= next_data_s;
      vram_write_data_odd  <= next_data_s;
      vram_we_even         <= next_mask_s[0];
      vram_we_odd          <= next_mask_s[1];
    end
  end

`ifdef VDP_VRAM_HOST_READ_EN
  assign host.host_read_ready = ready_s & ~host.host_write_valid;

  // Track each read pop until its data is on the VRAM read bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pipe_r <= (READ_LATENCY + 1)'(0);
    end else begin
      rd_pipe_r <= {rd_pipe_r[READ_LATENCY-1:0], pop_s & head_rd_s};
    end
  end

  // The valid flag is registered; the data is presented from the bus in the
  // cycle it becomes valid, READ_LATENCY+1 cycles after the pop.
  assign host.host_read_data_valid = rd_pipe_r[READ_LATENCY];
  assign host.host_read_data = rd_pipe_r[READ_LATENCY] ?
                               {vram_read_data_odd, vram_read_data_even} : 32'h0000_0000;
  assign unused_s = ^raster_x_offset[10:SLOT_BITS];
`else
  assign unused_s = ^{vram_read_data_even, vram_read_data_odd, raster_x_offset[10:SLOT_BITS]};
`endif
endmodule

// File: tb/tb_vdp_vram_slot_arbiter.sv
// Randomised self-checking bench for vdp_vram_slot_arbiter (default build).
// A queue-based model of the slot rules predicts every output each cycle;
// a few directed scenarios pin the model with hand-computed literals.
module tb_vdp_vram_slot_arbiter;
  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          reset;
  logic [10:0]   raster_x_offset;
  logic [AW-1:0] vram_sprite_address;
  logic [15:0]   vram_read_data_even, vram_read_data_odd;
  logic [AW-1:0] vram_address;
  logic [15:0]   vram_write_data_even, vram_write_data_odd;
  logic          vram_we_even, vram_we_odd, vram_written, vram_sprite_read_data_valid;
  logic [2:0]    fifo_level;

  vdp_vram_slot_arbiter_if #(.ADDR_W(AW)) hif ();

  vdp_vram_slot_arbiter dut (
    .clk                         (clk),
    .reset                       (reset),
    .raster_x_offset             (raster_x_offset),
    .host                        (hif),
    .vram_sprite_address         (vram_sprite_address),
    .vram_read_data_even         (vram_read_data_even),
    .vram_read_data_odd          (vram_read_data_odd),
    .vram_address                (vram_address),
    .vram_write_data_even        (vram_write_data_even),
    .vram_write_data_odd         (vram_write_data_odd),
    .vram_we_even                (vram_we_even),
    .vram_we_odd                 (vram_we_odd),
    .vram_written                (vram_written),
    .vram_sprite_read_data_valid (vram_sprite_read_data_valid),
    .fifo_level                  (fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   data;
    logic [1:0]    mask;
  } ent_t;

  ent_t          q[$];
  int            n_chk = 0;
  int            n_pass = 0;
  bit            regs_known = 1'b0;
  logic [AW-1:0] e_addr;
  logic [15:0]   e_data;
  logic [1:0]    e_we;
  bit            e_pop;
  logic [10:0]   xr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // One clock cycle: drive inputs, compare against the model, advance the model.
  task automatic step(input bit rst, input bit v, input logic [AW-1:0] a,
                      input logic [15:0] d, input logic [1:0] m, input logic [AW-1:0] sp);
    int   s;
    bit   pop;
    bit   push;
    ent_t e;
    @(negedge clk);
    reset                  = rst;
    raster_x_offset        = xr;
    vram_sprite_address    = sp;
    hif.host_write_valid   = v;
    hif.host_write_address = a;
    hif.host_write_data    = d;
    hif.host_write_en_mask = m;
    vram_read_data_even    = 16'($urandom);
    vram_read_data_odd     = 16'($urandom);
    #1;
    s = int'(xr) % 8;
    chk("sprite_valid", 32'(vram_sprite_read_data_valid), 32'(s == 5));
    if (regs_known) begin
      chk("fifo_level", 32'(fifo_level), 32'(q.size()));
      chk("ready", 32'(hif.host_write_ready), 32'(q.size() != 4));
      chk("written", 32'(vram_written), 32'(!rst && s == 0 && q.size() > 0));
      chk("vram_address", 32'(vram_address), 32'(e_addr));
      chk("we_even", 32'(vram_we_even), 32'(e_we[0]));
      chk("we_odd", 32'(vram_we_odd), 32'(e_we[1]));
      if (e_pop) begin
        chk("wdata_even", 32'(vram_write_data_even), 32'(e_data));
        chk("wdata_odd", 32'(vram_write_data_odd), 32'(e_data));
      end
    end
    if (rst) begin
      q.delete();
      e_addr = '0; e_data = '0; e_we = 2'b00; e_pop = 1'b0;
      regs_known = 1'b1;
    end else begin
      push   = v && (q.size() != 4);
      pop    = (s == 0) && (q.size() > 0);
      e_addr = '0; e_data = '0; e_we = 2'b00; e_pop = 1'b0;
      if (pop) begin
        e = q.pop_front();
        e_addr = e.addr; e_data = e.data; e_we = e.mask; e_pop = 1'b1;
      end else if (s == 1) begin
        e_addr = sp;
      end
      if (push) begin
        e.addr = a; e.data = d; e.mask = m;
        q.push_back(e);
      end
    end
    xr = xr + 11'd1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 2'b00, '0);
  endtask

  initial begin
    int rst_cnt;
    int dens;
    reset = 1'b1;
    hif.host_write_valid = 1'b0;
    hif.host_write_address = '0;
    hif.host_write_data = '0;
    hif.host_write_en_mask = 2'b00;
    raster_x_offset = '0;
    vram_sprite_address = '0;
    vram_read_data_even = '0;
    vram_read_data_odd = '0;
    xr = 11'd0;

    // Reset, then one write pushed at s=5 and popped at s=0.
    repeat (3) step(1'b1, 1'b0, '0, '0, 2'b00, '0);        // xr 0..2
    chk("lit_reset_level", 32'(fifo_level), 32'd0);
    chk("lit_reset_we", 32'({vram_we_odd, vram_we_even}), 32'd0);
    idle(2);                                                // xr 3,4
    step(1'b0, 1'b1, 14'h0123, 16'hBEEF, 2'b11, '0);       // xr 5
    idle(2);                                                // xr 6,7
    step(1'b0, 1'b0, '0, '0, 2'b00, '0);                   // xr 8, s=0
    chk("lit_written", 32'(vram_written), 32'd1);
    step(1'b0, 1'b0, '0, '0, 2'b00, 14'h2AAA);             // xr 9, s=1
    chk("lit_addr_0123", 32'(vram_address), 32'h0123);
    chk("lit_we_both", 32'({vram_we_odd, vram_we_even}), 32'd3);
    chk("lit_wdata", 32'(vram_write_data_even), 32'hBEEF);
    step(1'b0, 1'b0, '0, '0, 2'b00, '0);                   // xr 10
    chk("lit_sprite_addr", 32'(vram_address), 32'h2AAA);
    idle(2);                                                // xr 11,12
    chk("lit_sprite_valid_s4", 32'(vram_sprite_read_data_valid), 32'd0);
    step(1'b0, 1'b0, '0, '0, 2'b00, '0);                   // xr 13, s=5
    chk("lit_sprite_valid_s5", 32'(vram_sprite_read_data_valid), 32'd1);
    idle(3);                                                // xr 14..16

    // Five back-to-back pushes: only four fit.
    for (int i = 0; i < 5; i++)                             // xr 17..21
      step(1'b0, 1'b1, 14'(14'h100 + i), 16'(16'h1000 + i), 2'b11, '0);
    chk("lit_full_ready", 32'(hif.host_write_ready), 32'd0);
    chk("lit_full_level", 32'(fifo_level), 32'd4);
    idle(2);                                                // xr 22,23
    // Push attempt while full in the host slot: refused, level 4 -> 3.
    step(1'b0, 1'b1, 14'h3FFF, 16'hFFFF, 2'b11, '0);       // xr 24, s=0
    chk("lit_full_pop_written", 32'(vram_written), 32'd1);
    step(1'b0, 1'b0, '0, '0, 2'b00, '0);                   // xr 25
    chk("lit_level_4to3", 32'(fifo_level), 32'd3);
    chk("lit_first_drained", 32'(vram_address), 32'h0100);
    idle(24);                                               // xr 26..49, drains in order

    // Reset with three entries queued: nothing is ever written.
    for (int i = 0; i < 3; i++)                             // xr 50..52
      step(1'b0, 1'b1, 14'(14'h200 + i), 16'(16'h2000 + i), 2'b11, '0);
    step(1'b1, 1'b0, '0, '0, 2'b00, '0);                   // xr 53
    for (int i = 0; i < 5; i++) begin                       // xr 54..58
      step(1'b1, 1'b0, '0, '0, 2'b00, '0);
      chk("lit_rst_level", 32'(fifo_level), 32'd0);
      chk("lit_rst_we", 32'({vram_we_odd, vram_we_even}), 32'd0);
      chk("lit_rst_written", 32'(vram_written), 32'd0);
    end
    idle(10);

    // Randomised traffic with raster jumps and occasional resets.
    rst_cnt = 0;
    dens = 5;
    for (int i = 0; i < 3000; i++) begin
      if (i % 256 == 0) dens = $urandom_range(1, 9);
      if ($urandom_range(0, 199) == 0) rst_cnt = $urandom_range(1, 3);
      if ($urandom_range(0, 63) == 0) xr = 11'($urandom);
      step(rst_cnt > 0, $urandom_range(0, 9) < dens, 14'($urandom), 16'($urandom),
           2'($urandom), 14'($urandom));
      if (rst_cnt > 0) rst_cnt--;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/vdp_vram_slot_arbiter.md
VDP_VRAM_SLOT_ARBITER -- requirements
Module: vdp_vram_slot_arbiter

Interface
REQ-001 Parameter SLOT_BITS, default 3: the slot wheel has 2^SLOT_BITS slots.
REQ-002 Parameter HOST_SLOT, default 0: the slot that issues host accesses.
REQ-003 Parameter SPRITE_SLOT, default 1: the slot that issues the sprite address.
REQ-004 Parameter READ_LATENCY, default 3: cycles from a registered vram_address to valid read data.
REQ-005 Parameter FIFO_DEPTH_BITS, default 2: the host queue holds 2^FIFO_DEPTH_BITS entries.
REQ-006 Parameter ADDR_W, default 14: width of all VRAM word addresses.
REQ-007 clk  in  1  sole clock, rising edge.
REQ-008 reset  in  1  synchronous, active-high.
REQ-009 raster_x_offset  in  11  raster reference; the slot index is bits [SLOT_BITS-1:0].
REQ-010 host_write_valid / host_write_ready  in / out  1 / 1  host request handshake.
REQ-011 host_write_address / host_write_data / host_write_en_mask  in  ADDR_W / 16 / 2  request payload; mask bit 0 = even port, bit 1 = odd port.
REQ-012 vram_sprite_address  in  ADDR_W  sprite fetch address.
REQ-013 vram_read_data_even, vram_read_data_odd  in  16 each  VRAM read data.
REQ-014 vram_address  out  ADDR_W  registered VRAM address.
REQ-015 vram_write_data_even, vram_write_data_odd  out  16 each  registered write data.
REQ-016 vram_we_even, vram_we_odd  out  1 each  registered write enables.
REQ-017 vram_written  out  1  pulse marking a host-write pop.
REQ-018 vram_sprite_read_data_valid  out  1  sprite read data is valid this cycle.
REQ-019 fifo_level  out  FIFO_DEPTH_BITS+1  current queue occupancy.

Function
REQ-020 The block SHALL define slot s = raster_x_offset[SLOT_BITS-1:0].
REQ-021 host_write_ready SHALL equal (fifo_level != 2^FIFO_DEPTH_BITS); it depends only on the full flag, so a simultaneous pop does not raise ready.
REQ-022 When valid && ready, the block SHALL push the payload at the clock edge and increment fifo_level.
REQ-023 When s == HOST_SLOT and the queue is non-empty, the block SHALL pop the head entry, set next address/data/mask from that entry, and assert vram_written combinationally in that cycle.
REQ-024 An entry pushed at edge N SHALL NOT be poppable before the cycle following edge N; there is no bypass.
REQ-025 When s == HOST_SLOT and the queue is empty, the block SHALL set next address to 0, next mask to 0 and vram_written to 0.
REQ-026 When s == SPRITE_SLOT, the block SHALL set next address to vram_sprite_address and next mask to 0.
REQ-027 In all other slots the block SHALL set next address and next mask to 0; these slots are reserved for layer fetch.
REQ-028 vram_address, the write data and the write enables SHALL register their next values at every rising edge, giving 1-cycle latency.
REQ-029 vram_sprite_read_data_valid SHALL be 1 exactly when s == (SPRITE_SLOT+1+READ_LATENCY) mod 2^SLOT_BITS.
REQ-030 A simultaneous push and pop SHALL leave fifo_level unchanged.
REQ-031 Queue pointers SHALL wrap modulo 2^FIFO_DEPTH_BITS.
REQ-032 Queue order SHALL be strictly FIFO.
REQ-033 Slot arithmetic SHALL wrap modulo 2^SLOT_BITS.

Reset
REQ-034 While reset is high, the block SHALL empty the queue and discard all pending entries, including mid-stream.
REQ-035 While reset is high, the block SHALL hold fifo_level=0, vram_address=0, write data=0 and vram_we_*=0.
REQ-036 While reset is high, vram_written SHALL be 0, and host_write_ready SHALL be 1 from the first cycle after reset.

Configuration
REQ-037 With VDP_VRAM_HOST_READ_EN defined, the block SHALL add ports host_read_valid/host_read_ready (in/out, 1 each), host_read_address (in, ADDR_W), host_read_data (out, 32, {odd,even}) and host_read_data_valid (out, 1).
REQ-038 With VDP_VRAM_HOST_READ_EN defined, reads SHALL share the queue, carrying a read flag.
REQ-039 With VDP_VRAM_HOST_READ_EN defined, a write request SHALL take precedence over a read request in the same cycle.
REQ-040 With VDP_VRAM_HOST_READ_EN defined, a read pop SHALL drive the address with mask 0 and SHALL NOT assert vram_written.
REQ-041 With VDP_VRAM_HOST_READ_EN defined, READ_LATENCY+1 cycles after a read pop the block SHALL register the read data and pulse host_read_data_valid for 1 cycle.
REQ-042 With VDP_VRAM_HOST_READ_EN defined, reset SHALL clear host_read_data_valid.
REQ-043 Without VDP_VRAM_HOST_READ_EN, the read ports and logic SHALL be absent.

Verification
REQ-044 Scenario: push addr 0x0123, data 0xBEEF, mask 2'b11 while s=5 -> at s=0 vram_written=1; after the next edge vram_address=0x0123, vram_we_even=vram_we_odd=1.
REQ-045 Scenario: push 5 entries back-to-back with default depth -> ready drops after 4 pushes and fifo_level=4; entries drain one per 8-cycle wheel in order.
REQ-046 Scenario: push while full in the HOST_SLOT cycle -> push refused and fifo_level goes 4->3.
REQ-047 Scenario: vram_sprite_address=0x2AAA with the wheel running -> vram_address=0x2AAA after the s=1 edge; vram_sprite_read_data_valid is high only at s=5.
REQ-048 Scenario: assert reset with 3 entries queued -> fifo_level=0 and no write enable ever pulses.
REQ-049 Scenario, VDP_VRAM_HOST_READ_EN defined: read addr 0x0040 popped at s=0 -> host_read_data_valid pulses at s=4 with {odd,even} data.
